// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between an instruction cache
// (read-only line fills) and a data cache (line fills and writebacks).
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   i_pmem_read/address            I-cache fill request
//   i_pmem_rdata/resp              I-cache return line and one-cycle completion
//   d_pmem_read/write/address/wdata D-cache fill / writeback request
//   d_pmem_rdata/resp              D-cache return line and one-cycle completion
//   pmem_read/write/address/wdata  physical memory request (registered)
//   pmem_rdata/resp                physical memory return line and completion
//   i_grant_cnt, d_grant_cnt       per-side grant counters (wrap at 16 bits)
//
// Build option
//   ARB_ROUND_ROBIN_EN  defined: simultaneous requests alternate between sides.
//                       undefined: the D side always wins simultaneous requests.
//
// The x_pmem_resp / x_pmem_rdata outputs are combinational from pmem_resp so
// the completion pulse lands in the same cycle memory responds.

module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [15:0]       i_grant_cnt,
    output logic [15:0]       d_grant_cnt
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_req_i;
    logic               w_req_d;
    logic               w_d_wins;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_done;

    logic [ADDR_W-1:0]  r_addr;
    logic [LINE_W-1:0]  r_wdata;
    logic               r_read;
    logic               r_write;
    logic [CNT_W-1:0]   r_i_cnt;
    logic [CNT_W-1:0]   r_d_cnt;

    assign w_req_i = i_pmem_read;
    // A simultaneous read+write from the D side is a writeback.
    assign w_req_d = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    // Priority pointer: 1 = D side preferred on a tie.
    logic r_prio_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio_d <= 1'b1;
        end else if (w_grant_d) begin
            r_prio_d <= 1'b0;
        end else if (w_grant_i) begin
            r_prio_d <= 1'b1;
        end
    end

    assign w_d_wins = r_prio_d;
`else
    assign w_d_wins = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, grant decisions and same-cycle completion outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done       = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_rdata = '0;

        case (r_state)
            IDLE: begin
                if (w_req_d && (w_d_wins || !w_req_i)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = GRANT_D;
                end else if (w_req_i) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = GRANT_I;
                end
            end
            GRANT_I: begin
                if (pmem_resp) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
                // Reset in the same cycle abandons the transaction silently.
                i_pmem_resp = pmem_resp & ~reset;
            end
            GRANT_D: begin
                if (pmem_resp) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
                d_pmem_resp = pmem_resp & ~reset;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (i_pmem_resp) begin
            i_pmem_rdata = pmem_rdata;
        end
        if (d_pmem_resp) begin
            d_pmem_rdata = pmem_rdata;
        end
    end

    // Latched request payload, strobes and grant counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_i_cnt <= '0;
            r_d_cnt <= '0;
        end else if (w_grant_d) begin
            r_addr  <= d_pmem_address;
            r_wdata <= d_pmem_wdata;
            r_write <= d_pmem_write;
            r_read  <= ~d_pmem_write;
            r_d_cnt <= r_d_cnt + CNT_W'(1);
        end else if (w_grant_i) begin
            r_addr  <= i_pmem_address;
            r_wdata <= '0;
            r_read  <= 1'b1;
            r_write <= 1'b0;
            r_i_cnt <= r_i_cnt + CNT_W'(1);
        end else if (w_done) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end
    end

    assign pmem_read    = r_read;
    assign pmem_write   = r_write;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign i_grant_cnt  = r_i_cnt;
    assign d_grant_cnt  = r_d_cnt;

endmodule
